// File: rtl/rv_dmem_pkg.sv
// Shared types and constants for the data-memory responder: the core request
// struct, the MMIO page map, the legal byte-enable encodings and the load helpers.
package rv_dmem_pkg;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] wr_data;
        logic        wr_en;
        logic [3:0]  byte_en;
    } t_core2mem_req;

    localparam logic [31:0] MMIO_BASE   = 32'hFFFF_0000;
    localparam logic [3:0]  MMIO_TOHOST = 4'h0;
    localparam logic [3:0]  MMIO_CYCLE  = 4'h4;
    localparam logic [3:0]  MMIO_CONS   = 4'h8;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    // Right-justify the enabled lanes and extend; illegal patterns yield 0.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [3:0]  be,
                                                 input logic        sext);
        logic [31:0] res;
        res = 32'h0;
        case (be)
            BE_B0:   res = {{24{sext & word[7]}},  word[7:0]};
            BE_B1:   res = {{24{sext & word[15]}}, word[15:8]};
            BE_B2:   res = {{24{sext & word[23]}}, word[23:16]};
            BE_B3:   res = {{24{sext & word[31]}}, word[31:24]};
            BE_H0:   res = {{16{sext & word[15]}}, word[15:0]};
            BE_H1:   res = {{16{sext & word[31]}}, word[31:16]};
            BE_W:    res = word;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rv_dmem_cons_fifo.sv
// Console byte FIFO: valid/ready pop side, drop-and-flag push side when full.
// DEPTH must be a power of two, at least 2.
module rv_dmem_cons_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       full,
    output logic       pop_valid,
    output logic [7:0] pop_data,
    input  logic       pop_ready,
    output logic       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          do_push, do_pop;

    assign pop_valid = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign pop_data  = pop_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign overflow  = overflow_q;

    // A pop frees the slot the same cycle, so a push into a full FIFO is kept.
    always_comb begin
        do_pop     = pop_valid && pop_ready;
        do_push    = push && (!full || do_pop);
        wr_ptr_d   = wr_ptr_q + PW'(do_push);
        rd_ptr_d   = rd_ptr_q + PW'(do_pop);
        count_d    = count_q + CW'(do_push) - CW'(do_pop);
        overflow_d = overflow_q || (push && !do_push);
    end

    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/rv_dmem_resp.sv
// Data-memory responder for the core data port: byte/half/word RAM, 1-cycle loads.
// Define RV_DMEM_MMIO_EN to build the tohost / cycle-counter / console MMIO page.
module rv_dmem_resp
    import rv_dmem_pkg::*;
#(
    parameter int MEM_SIZE_BYTES = 1024,
    parameter int CONS_DEPTH     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  t_core2mem_req core2dmem_req,
    input  logic          is_signed,
    output logic [31:0]   dmem_rd_data,
    output logic          misalign_err,
    output logic          tohost_valid,
    output logic [31:0]   tohost_data,
    output logic          cons_valid,
    output logic [7:0]    cons_data,
    input  logic          cons_ready,
    output logic          cons_overflow
);
    localparam int MEM_WORDS = MEM_SIZE_BYTES / 4;
    localparam int IW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [31:0]   ram_q [MEM_WORDS];
    logic [IW-1:0] ram_idx;
    logic [31:0]   ram_word;
    logic [3:0]    be;
    logic          be_any, be_ok, is_load, is_store, ram_we;
    logic          mmio_hit;
    logic [31:0]   mmio_word;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          misalign_q, misalign_d;
    logic          unused_ok;

    assign be       = core2dmem_req.byte_en;
    assign be_any   = |be;
    assign be_ok    = be_legal(be);
    assign is_store = core2dmem_req.wr_en && be_any && be_ok;
    assign is_load  = !core2dmem_req.wr_en && be_any;
    assign ram_idx  = IW'(core2dmem_req.address[31:2] & 30'(MEM_WORDS - 1));
    assign ram_word = ram_q[ram_idx];
    assign ram_we   = is_store && !mmio_hit;

    // NOTE: RAM contents are intentionally not reset; only the write enable is gated by rst.
    always_ff @(posedge clk) begin
        if (rst && ram_we) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) ram_q[ram_idx][8*l +: 8] <= core2dmem_req.wr_data[8*l +: 8];
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rd_data_d  = rd_data_q;
        misalign_d = misalign_q || (be_any && !be_ok);
        if (is_load) begin
            rd_data_d = load_extract(mmio_hit ? mmio_word : ram_word, be, is_signed);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q  <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            misalign_q <= misalign_d;
        end
    end

    assign dmem_rd_data = rd_data_q;
    assign misalign_err = misalign_q;

`ifdef RV_DMEM_MMIO_EN
    logic [3:0]  mmio_off;
    logic        tohost_valid_q, tohost_valid_d;
    logic [31:0] tohost_data_q, tohost_data_d;
    logic [31:0] cycle_q, cycle_d;
    logic        cons_push, cons_full;

    assign mmio_hit = (core2dmem_req.address[31:4] == MMIO_BASE[31:4]);
    assign mmio_off = {core2dmem_req.address[3:2], 2'b00};

    always_comb begin
        tohost_valid_d = tohost_valid_q;
        tohost_data_d  = tohost_data_q;
        cycle_d        = cycle_q + 32'd1;
        cons_push      = 1'b0;
        case (mmio_off)
            MMIO_TOHOST: mmio_word = tohost_data_q;
            MMIO_CYCLE:  mmio_word = cycle_q;
            MMIO_CONS:   mmio_word = {31'h0, cons_full};
            default:     mmio_word = 32'h0;
        endcase
        if (is_store && mmio_hit) begin
            // A zero store to tohost is a no-op so the flag can only ever rise.
            if (mmio_off == MMIO_TOHOST && core2dmem_req.wr_data != 32'h0) begin
                tohost_valid_d = 1'b1;
                tohost_data_d  = core2dmem_req.wr_data;
            end
            cons_push = (mmio_off == MMIO_CONS);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tohost_valid_q <= 1'b0;
            tohost_data_q  <= 32'h0;
            cycle_q        <= 32'h0;
        end else begin
            tohost_valid_q <= tohost_valid_d;
            tohost_data_q  <= tohost_data_d;
            cycle_q        <= cycle_d;
        end
    end

    rv_dmem_cons_fifo #(
        .DEPTH(CONS_DEPTH)
    ) u_cons_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (cons_push),
        .push_data(core2dmem_req.wr_data[7:0]),
        .full     (cons_full),
        .pop_valid(cons_valid),
        .pop_data (cons_data),
        .pop_ready(cons_ready),
        .overflow (cons_overflow)
    );

    assign tohost_valid = tohost_valid_q;
    assign tohost_data  = tohost_data_q;
    assign unused_ok    = ^core2dmem_req.address[1:0];
`else
    assign mmio_hit      = 1'b0;
    assign mmio_word     = 32'h0;
    assign tohost_valid  = 1'b0;
    assign tohost_data   = 32'h0;
    assign cons_valid    = 1'b0;
    assign cons_data     = 8'h00;
    assign cons_overflow = 1'b0;
    assign unused_ok     = ^{core2dmem_req.address[1:0], cons_ready};
`endif

endmodule

// File: tb/tb_rv_dmem_resp.sv
// Self-checking bench for rv_dmem_resp: directed cases plus random traffic against
// a byte-array / queue reference model. MMIO cases build when RV_DMEM_MMIO_EN is defined.
`timescale 1ns/1ps
module tb_rv_dmem_resp;
    import rv_dmem_pkg::*;

    localparam int MEM_BYTES = 1024;
    localparam int DEPTH     = 8;

    logic          clk = 1'b0;
    logic          rst;
    t_core2mem_req req;
    logic          is_signed, cons_ready;
    logic [31:0]   dmem_rd_data, tohost_data;
    logic          misalign_err, tohost_valid, cons_valid, cons_overflow;
    logic [7:0]    cons_data;

    rv_dmem_resp #(
        .MEM_SIZE_BYTES(MEM_BYTES),
        .CONS_DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core2dmem_req(req),
        .is_signed    (is_signed),
        .dmem_rd_data (dmem_rd_data),
        .misalign_err (misalign_err),
        .tohost_valid (tohost_valid),
        .tohost_data  (tohost_data),
        .cons_valid   (cons_valid),
        .cons_data    (cons_data),
        .cons_ready   (cons_ready),
        .cons_overflow(cons_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0]  m_mem [MEM_BYTES];
    logic [31:0] m_rd;
    bit          m_rd_known;
    bit          m_mis, m_th_valid, m_ovf;
    logic [31:0] m_th_data;
    logic [7:0]  m_cons [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Legal = a naturally aligned run of 1, 2 or 4 bytes.
    function automatic bit model_be_ok(input logic [3:0] be);
        for (int n = 1; n <= 4; n = n * 2)
            for (int lo = 0; lo < 4; lo += n)
                if (be == 4'(((1 << n) - 1) << lo)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_extract(input logic [31:0] w, input logic [3:0] be, input bit sgn);
        int     lo = 0;
        int     n  = 0;
        longint v;
        for (int l = 0; l < 4; l++) if (be[l]) begin if (n == 0) lo = l; n++; end
        v = longint'(w >> (8 * lo)) & ((longint'(1) << (8 * n)) - 1);
        if (sgn && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int base = int'(a & 32'(MEM_BYTES - 4));
        return {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
    endfunction

`ifdef RV_DMEM_MMIO_EN
    function automatic bit is_mmio(input logic [31:0] a);
        return a[31:4] == 28'hFFFF000;
    endfunction
`else
    function automatic bit is_mmio(input logic [31:0] a);
        return a[31:4] == 28'h0 && a[0] && !a[0];
    endfunction
`endif

    task automatic model_reset();
        m_rd = 32'h0; m_rd_known = 1'b1; m_mis = 1'b0;
        m_th_valid = 1'b0; m_th_data = 32'h0; m_ovf = 1'b0;
        m_cons.delete();
    endtask

    // One request cycle: drive at negedge, model the posedge, return at the next negedge.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input bit we,
                          input logic [3:0] be, input bit sgn);
        bit ok, push, pop;
        int base;
        req = '{address: a, wr_data: d, wr_en: we, byte_en: be};
        is_signed = sgn;
        @(posedge clk);
        ok   = (be != 4'h0) && model_be_ok(be);
        push = 1'b0;
        if (be != 4'h0 && !ok) m_mis = 1'b1;
        if (is_mmio(a)) begin
            if (we && ok) begin
                if (a[3:2] == 2'd0 && d != 32'h0) begin m_th_valid = 1'b1; m_th_data = d; end
                push = (a[3:2] == 2'd2);
            end else if (!we && be != 4'h0) begin
                m_rd_known = 1'b1;
                case (a[3:2])
                    2'd0:    m_rd = ok ? model_extract(m_th_data, be, sgn) : 32'h0;
                    2'd1:    m_rd_known = 1'b0;
                    2'd2:    m_rd = ok ? model_extract({31'h0, m_cons.size() == DEPTH}, be, sgn) : 32'h0;
                    default: m_rd = 32'h0;
                endcase
            end
        end else if (we && ok) begin
            base = int'(a & 32'(MEM_BYTES - 4));
            for (int l = 0; l < 4; l++) if (be[l]) m_mem[base + l] = d[8*l +: 8];
        end else if (!we && be != 4'h0) begin
            m_rd = ok ? model_extract(model_word(a), be, sgn) : 32'h0;
            m_rd_known = 1'b1;
        end
`ifdef RV_DMEM_MMIO_EN
        pop = cons_ready && (m_cons.size() > 0);
        if (push && m_cons.size() == DEPTH && !pop) m_ovf = 1'b1;
        if (pop) void'(m_cons.pop_front());
        if (push && m_cons.size() < DEPTH) m_cons.push_back(d[7:0]);
`else
        pop = 1'b0;
`endif
        @(negedge clk);
        req = '0;
    endtask

    task automatic check_outputs(input string tag);
        if (m_rd_known) check({tag, ".rd"}, dmem_rd_data, m_rd);
        check({tag, ".mis"}, misalign_err, m_mis);
`ifdef RV_DMEM_MMIO_EN
        check({tag, ".th_v"}, tohost_valid, m_th_valid);
        check({tag, ".th_d"}, tohost_data, m_th_data);
        check({tag, ".c_v"}, cons_valid, m_cons.size() > 0);
        check({tag, ".c_d"}, cons_data, (m_cons.size() > 0) ? m_cons[0] : 8'h00);
        check({tag, ".c_ovf"}, cons_overflow, m_ovf);
`else
        check({tag, ".ties"}, {tohost_valid, tohost_data, cons_valid, cons_data, cons_overflow}, 32'h0);
`endif
    endtask

    localparam logic [3:0] LEGAL_BE [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    initial begin
        logic [31:0] v1, v2;
        logic [3:0]  rbe;
        rst = 1'b0; req = '0; is_signed = 1'b0; cons_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_outputs("reset");

        for (int i = 0; i < MEM_BYTES / 4; i++) do_req(32'(i * 4), 32'h0, 1'b1, 4'hF, 1'b0);

        do_req(32'h0, 32'h0000_001E, 1'b1, 4'hF, 1'b0);
        do_req(32'h0, 32'h0, 1'b0, 4'hF, 1'b0);
        check("lw_after_sw", dmem_rd_data, 32'h0000_001E);
        check("no_misalign", misalign_err, 1'b0);

        do_req(32'h4, 32'h8081_F0FE, 1'b1, 4'hF, 1'b0);
        do_req(32'h6, 32'h0, 1'b0, 4'b0100, 1'b1);
        check("lb_signed", dmem_rd_data, 32'hFFFF_FF81);
        do_req(32'h6, 32'h0, 1'b0, 4'b0100, 1'b0);
        check("lbu", dmem_rd_data, 32'h0000_0081);
        do_req(32'h6, 32'h0, 1'b0, 4'b1100, 1'b0);
        check("lhu_upper", dmem_rd_data, 32'h0000_8081);
        do_req(32'h4, 32'h0000_00AA, 1'b1, 4'b0001, 1'b0);
        do_req(32'h4, 32'h0, 1'b0, 4'hF, 1'b0);
        check("sb_then_lw", dmem_rd_data, 32'h8081_F0AA);
        do_req(32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        check("idle_hold", dmem_rd_data, 32'h8081_F0AA);
        check_outputs("directed");

        do_req(32'h8, 32'h1234_5678, 1'b1, 4'hF, 1'b0);
        do_req(32'h8, 32'hFFFF_FFFF, 1'b1, 4'b0101, 1'b0);
        check("misalign_set", misalign_err, 1'b1);
        do_req(32'h408, 32'h0, 1'b0, 4'hF, 1'b0);
        check("wrap_unchanged", dmem_rd_data, 32'h1234_5678);
        check("misalign_sticky", misalign_err, 1'b1);
        do_req(32'h8, 32'h0, 1'b0, 4'b0110, 1'b0);
        check("illegal_load", dmem_rd_data, 32'h0);

        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        check_outputs("reset2");

        for (int i = 0; i < 400; i++) begin
            rbe = ($urandom_range(0, 3) != 0) ? LEGAL_BE[$urandom_range(0, 6)] : 4'($urandom_range(0, 15));
            do_req(32'($urandom_range(0, 4095)), $urandom, 1'($urandom_range(0, 1)), rbe, 1'($urandom_range(0, 1)));
            check_outputs("rand");
        end

`ifdef RV_DMEM_MMIO_EN
        cons_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            do_req(32'hFFFF_0008, 32'h30 + 32'(i), 1'b1, 4'hF, 1'b0);
            check_outputs("cons_fill");
        end
        do_req(32'hFFFF_0008, 32'h0, 1'b0, 4'hF, 1'b0);
        check("cons_full_flag", dmem_rd_data, 32'h1);
        cons_ready = 1'b1;
        do_req(32'hFFFF_0008, 32'h38, 1'b1, 4'hF, 1'b0);
        check("full_pushpop_ovf", cons_overflow, 1'b0);
        check("full_pushpop_head", cons_data, 8'h31);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_a", cons_data, 8'h31 + 8'(i));
            do_req(32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
            check_outputs("drain_a");
        end
        check("drain_a_empty", cons_valid, 1'b0);
        do_req(32'hFFFF_0008, 32'h39, 1'b1, 4'hF, 1'b0);
        check("empty_pushpop", {cons_valid, cons_data}, {1'b1, 8'h39});
        do_req(32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        check_outputs("empty_pushpop");

        cons_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_req(32'hFFFF_0008, 32'h41 + 32'(i), 1'b1, 4'hF, 1'b0);
            check_outputs("cons_push9");
        end
        check("cons_overflow", cons_overflow, 1'b1);
        cons_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_b", cons_data, 8'h41 + 8'(i));
            do_req(32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
            check_outputs("drain_b");
        end
        check("drain_b_empty", cons_valid, 1'b0);
        cons_ready = 1'b0;

        do_req(32'hFFFF_0000, 32'h0, 1'b1, 4'hF, 1'b0);
        check("tohost_zero", tohost_valid, 1'b0);
        do_req(32'hFFFF_0000, 32'h1, 1'b1, 4'hF, 1'b0);
        check("tohost_valid", tohost_valid, 1'b1);
        check("tohost_data", tohost_data, 32'h1);
        do_req(32'hFFFF_0000, 32'h0, 1'b0, 4'hF, 1'b0);
        check("tohost_load", dmem_rd_data, 32'h1);
        do_req(32'hFFFF_000C, 32'h5, 1'b1, 4'hF, 1'b0);
        do_req(32'hFFFF_000C, 32'h0, 1'b0, 4'hF, 1'b0);
        check("reserved_load", dmem_rd_data, 32'h0);
        do_req(32'h0, 32'h0, 1'b0, 4'hF, 1'b0);
        check_outputs("mmio_no_ram");

        do_req(32'hFFFF_0004, 32'h0, 1'b0, 4'hF, 1'b0);
        v1 = dmem_rd_data;
        do_req(32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        do_req(32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
        do_req(32'hFFFF_0004, 32'h0, 1'b0, 4'hF, 1'b0);
        v2 = dmem_rd_data;
        check("cycle_diff", v2 - v1, 32'd3);
`else
        do_req(32'hFFFF_0004, 32'hCAFE_0001, 1'b1, 4'hF, 1'b0);
        do_req(32'h4, 32'h0, 1'b0, 4'hF, 1'b0);
        check("mmio_alias", dmem_rd_data, 32'hCAFE_0001);
        check_outputs("no_mmio");
`endif

        do_req(32'h4, 32'h0, 1'b0, 4'hF, 1'b0);
        do_req(32'h20, 32'h0, 1'b1, 4'b0101, 1'b0);
        do_req(32'hFFFF_0000, 32'h5, 1'b1, 4'hF, 1'b0);
        do_req(32'hFFFF_0008, 32'h77, 1'b1, 4'hF, 1'b0);
        check_outputs("pre_rst");
        rst = 1'b0;
        req = '{address: 32'h10, wr_data: 32'hDEAD_BEEF, wr_en: 1'b1, byte_en: 4'hF};
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        model_reset();
        check_outputs("rst_mid");
        check("rst_mid_rd", dmem_rd_data, 32'h0);
        do_req(32'h10, 32'h0, 1'b0, 4'hF, 1'b0);
        check_outputs("rst_store_dropped");
`ifdef RV_DMEM_MMIO_EN
        do_req(32'hFFFF_0004, 32'h0, 1'b0, 4'hF, 1'b0);
        check("cycle_after_rst", dmem_rd_data, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
